// File: rtl/approx_adder_err_monitor.sv
// Two-stage streaming lower-part-OR approximate adder with exact reference, error flagging and statistics.
// Define WORST_CAPTURE_EN to add worst_a/worst_b, the operands of the largest-error sample.
module approx_adder_err_monitor #(
   parameter int WIDTH       = 4,
   parameter int APPROX_BITS = 2,
   parameter int ET          = 3,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH:0]     out_sum,
   output logic [WIDTH:0]     out_exact,
   output logic [WIDTH:0]     out_err,
   output logic               out_viol,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic [CNT_W-1:0]   viol_cnt,
   output logic [WIDTH:0]     max_err
`ifdef WORST_CAPTURE_EN
   ,
   output logic [WIDTH-1:0]   worst_a,
   output logic [WIDTH-1:0]   worst_b
`endif
);

   localparam logic [31:0]      ET_U    = 32'(ET);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             advance;
   logic             handshake;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH:0]   calc_sum;
   logic [WIDTH:0]   calc_exact;
   logic [WIDTH:0]   calc_err;
   logic             calc_viol;
   logic             carry;

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign handshake = out_valid && out_ready;

   // Low part ORs; the top approximate bit pair generates the carry into the exact upper ripple.
   always_comb begin
      carry    = 1'b0;
      calc_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < APPROX_BITS) begin
            calc_sum[i] = s1_a[i] | s1_b[i];
            if (i == APPROX_BITS - 1)
               carry = s1_a[i] & s1_b[i];
         end else begin
            calc_sum[i] = s1_a[i] ^ s1_b[i] ^ carry;
            carry       = (s1_a[i] & s1_b[i]) | (carry & (s1_a[i] ^ s1_b[i]));
         end
      end
      calc_sum[WIDTH] = carry;
   end

   always_comb begin
      calc_exact = {1'b0, s1_a} + {1'b0, s1_b};
      calc_err   = (calc_exact >= calc_sum) ? (calc_exact - calc_sum) : (calc_sum - calc_exact);
      calc_viol  = 32'(calc_err) > ET_U;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_exact <= '0;
         out_err   <= '0;
         out_viol  <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s1_a      <= in_a;
         s1_b      <= in_b;
         out_valid <= s1_valid;
         out_sum   <= calc_sum;
         out_exact <= calc_exact;
         out_err   <= calc_err;
         out_viol  <= calc_viol;
      end
   end

   // Clear beats a coincident handshake; counters stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         sample_cnt <= '0;
         viol_cnt   <= '0;
         max_err    <= '0;
      end else if (handshake) begin
         if (sample_cnt != CNT_MAX)
            sample_cnt <= sample_cnt + 1'b1;
         if (out_viol && (viol_cnt != CNT_MAX))
            viol_cnt <= viol_cnt + 1'b1;
         if (out_err > max_err)
            max_err <= out_err;
      end
   end

`ifdef WORST_CAPTURE_EN
   logic [WIDTH-1:0] s2_a;
   logic [WIDTH-1:0] s2_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_a <= '0;
         s2_b <= '0;
      end else if (advance) begin
         s2_a <= s1_a;
         s2_b <= s1_b;
      end
   end

   // Strictly greater keeps the earliest operands on ties.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         worst_a <= '0;
         worst_b <= '0;
      end else if (handshake && (out_err > max_err)) begin
         worst_a <= s2_a;
         worst_b <= s2_b;
      end
   end
`endif

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Randomized and directed bench for approx_adder_err_monitor; two instances (defaults, and ET=1/CNT_W=2)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_approx_adder_err_monitor;

   localparam int W = 4;
   localparam int K = 2;
   localparam int ET_T  [2] = '{3, 1};
   localparam int CAP   [2] = '{65535, 3};

   typedef struct {
      int a;
      int b;
   } pair_t;

   logic clk = 1'b0;
   logic rst, in_valid, out_ready, clr_stats;
   logic [W-1:0] in_a, in_b;

   logic         in_ready0, out_valid0, out_viol0;
   logic [W:0]   out_sum0, out_exact0, out_err0, max_err0;
   logic [15:0]  sample_cnt0, viol_cnt0;
   logic         in_ready1, out_valid1, out_viol1;
   logic [W:0]   out_sum1, out_exact1, out_err1, max_err1;
   logic [1:0]   sample_cnt1, viol_cnt1;
`ifdef WORST_CAPTURE_EN
   logic [W-1:0] worst_a0, worst_b0, worst_a1, worst_b1;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   pair_t q0[$];
   pair_t q1[$];
   int m_cnt[2], m_viol[2], m_max[2], m_wa[2], m_wb[2];

   always #5 clk = ~clk;

   approx_adder_err_monitor #(.WIDTH(W), .APPROX_BITS(K), .ET(3), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0), .out_exact(out_exact0),
      .out_err(out_err0), .out_viol(out_viol0), .clr_stats(clr_stats), .sample_cnt(sample_cnt0),
      .viol_cnt(viol_cnt0), .max_err(max_err0)
`ifdef WORST_CAPTURE_EN
      , .worst_a(worst_a0), .worst_b(worst_b0)
`endif
   );

   approx_adder_err_monitor #(.WIDTH(W), .APPROX_BITS(K), .ET(1), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_exact(out_exact1),
      .out_err(out_err1), .out_viol(out_viol1), .clr_stats(clr_stats), .sample_cnt(sample_cnt1),
      .viol_cnt(viol_cnt1), .max_err(max_err1)
`ifdef WORST_CAPTURE_EN
      , .worst_a(worst_a1), .worst_b(worst_b1)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_approx(input int a, input int b);
      int low, c;
      low = (a | b) & ((1 << K) - 1);
      c   = (K > 0) ? ((a >> (K - 1)) & (b >> (K - 1)) & 1) : 0;
      return low + (((a >> K) + (b >> K) + c) << K);
   endfunction

   function automatic int ref_err(input int a, input int b);
      int s, e;
      s = ref_approx(a, b);
      e = a + b;
      return (e > s) ? e - s : s - e;
   endfunction

   task automatic check_res(input int d, input pair_t p, input int sum, input int exact,
                            input int err, input int viol);
      chk($sformatf("sum%0d(%0d+%0d)", d, p.a, p.b), sum, ref_approx(p.a, p.b));
      chk($sformatf("exact%0d", d), exact, p.a + p.b);
      chk($sformatf("err%0d", d), err, ref_err(p.a, p.b));
      chk($sformatf("viol%0d", d), viol, int'(ref_err(p.a, p.b) > ET_T[d]));
   endtask

   task automatic stats_step(input int d, input bit hs, input pair_t p);
      int e;
      if (clr_stats) begin
         m_cnt[d] = 0; m_viol[d] = 0; m_max[d] = 0; m_wa[d] = 0; m_wb[d] = 0;
      end else if (hs) begin
         e = ref_err(p.a, p.b);
         if (m_cnt[d] < CAP[d]) m_cnt[d]++;
         if (e > ET_T[d] && m_viol[d] < CAP[d]) m_viol[d]++;
         if (e > m_max[d]) begin
            m_max[d] = e; m_wa[d] = p.a; m_wb[d] = p.b;
         end
      end
   endtask

   pair_t p0, p1;
   bit    hs0, hs1;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("sample_cnt0", int'(sample_cnt0), m_cnt[0]);
         chk("viol_cnt0",   int'(viol_cnt0),   m_viol[0]);
         chk("max_err0",    int'(max_err0),    m_max[0]);
         chk("sample_cnt1", int'(sample_cnt1), m_cnt[1]);
         chk("viol_cnt1",   int'(viol_cnt1),   m_viol[1]);
         chk("max_err1",    int'(max_err1),    m_max[1]);
`ifdef WORST_CAPTURE_EN
         chk("worst_a0", int'(worst_a0), m_wa[0]);
         chk("worst_b0", int'(worst_b0), m_wb[0]);
         chk("worst_a1", int'(worst_a1), m_wa[1]);
         chk("worst_b1", int'(worst_b1), m_wb[1]);
`endif
         chk("orphan0", int'(out_valid0 && q0.size() == 0), 0);
         chk("orphan1", int'(out_valid1 && q1.size() == 0), 0);
         if (out_valid0 && q0.size() > 0)
            check_res(0, q0[0], int'(out_sum0), int'(out_exact0), int'(out_err0), int'(out_viol0));
         if (out_valid1 && q1.size() > 0)
            check_res(1, q1[0], int'(out_sum1), int'(out_exact1), int'(out_err1), int'(out_viol1));
         if (rst) begin
            q0.delete(); q1.delete();
            for (int d = 0; d < 2; d++) begin
               m_cnt[d] = 0; m_viol[d] = 0; m_max[d] = 0; m_wa[d] = 0; m_wb[d] = 0;
            end
         end else begin
            hs0 = out_valid0 && out_ready && q0.size() > 0;
            hs1 = out_valid1 && out_ready && q1.size() > 0;
            p0 = '{0, 0};
            p1 = '{0, 0};
            if (hs0) p0 = q0.pop_front();
            if (hs1) p1 = q1.pop_front();
            stats_step(0, hs0, p0);
            stats_step(1, hs1, p1);
            if (in_valid && in_ready0) q0.push_back('{int'(in_a), int'(in_b)});
            if (in_valid && in_ready1) q1.push_back('{int'(in_a), int'(in_b)});
         end
      end
   end

   task automatic send(input int a, input int b);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = W'(a);
      in_b = W'(b);
   endtask

   task automatic stop_in();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_stats = 1'b1;
      @(posedge clk); #1 clr_stats = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk({tag, "_q0"}, q0.size(), 0);
      chk({tag, "_q1"}, q1.size(), 0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_viol[d] = 0; m_max[d] = 0; m_wa[d] = 0; m_wb[d] = 0;
      end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0; in_a = '0; in_b = '0;
      @(posedge clk); #1 mon_en = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid0), 0);
      chk("rst_in_ready", int'(in_ready0), 1);
      chk("rst_out_sum", int'(out_sum0), 0);

      // single sample: latency and values
      send(3, 1);
      stop_in();
      @(negedge clk) chk("lat_e1", int'(out_valid0), 0);
      @(negedge clk) chk("lat_e2", int'(out_valid0), 1);
      chk("tp1_sum", int'(out_sum0), 3);
      chk("tp1_exact", int'(out_exact0), 4);
      chk("tp1_err", int'(out_err0), 1);
      chk("tp1_viol", int'(out_viol0), 0);
      @(negedge clk) chk("tp1_cnt", int'(sample_cnt0), 1);

      // back-to-back stream against ET=1
      pulse_clr();
      send(2, 2); send(3, 1); send(2, 2);
      @(negedge clk) chk("bb_viol_a", int'(out_viol1), 1);
      chk("bb_valid_a", int'(out_valid1), 1);
      stop_in();
      @(negedge clk) chk("bb_viol_b", int'(out_viol1), 0);
      chk("bb_valid_b", int'(out_valid1), 1);
      @(negedge clk) chk("bb_viol_c", int'(out_viol1), 1);
      chk("bb_valid_c", int'(out_valid1), 1);
      @(negedge clk);
      chk("bb_cnt", int'(sample_cnt1), 3);
      chk("bb_vcnt", int'(viol_cnt1), 2);

      // carry-out and above-exact cases
      pulse_clr();
      send(15, 15); send(2, 2);
      stop_in();
      drain("tp2");
      @(negedge clk) chk("tp2_max", int'(max_err0), 2);

      // stall with input pressure
      pulse_clr();
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a = W'($urandom_range(0, 15));
         in_b = W'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      chk("stall_in_ready", int'(in_ready0), 0);
      chk("stall_cnt", int'(sample_cnt0), 0);
      in_valid = 1'b0; out_ready = 1'b1;
      drain("stall");

      // reset with two samples in flight
      send(1, 2); send(3, 3);
      @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid0), 0);
      chk("mid_rst_cnt", int'(sample_cnt0), 0);

      send(2, 2); send(3, 3);
      stop_in();
      drain("worst");
`ifdef WORST_CAPTURE_EN
      @(negedge clk);
      chk("worst_a_tp", int'(worst_a0), 2);
      chk("worst_b_tp", int'(worst_b0), 2);
`endif

      // clear coinciding with a handshake
      send(1, 1);
      stop_in();
      @(posedge clk); #1 clr_stats = 1'b1;
      @(posedge clk); #1 clr_stats = 1'b0;
      @(negedge clk) chk("clr_hs_cnt", int'(sample_cnt0), 0);

      // saturation of the narrow counters
      pulse_clr();
      for (int i = 0; i < 6; i++) send(2, 2);
      stop_in();
      drain("sat");
      @(negedge clk);
      chk("sat_cnt1", int'(sample_cnt1), 3);
      chk("sat_vcnt1", int'(viol_cnt1), 3);
      chk("sat_cnt0", int'(sample_cnt0), 6);

      // random traffic with occasional clears and resets
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = W'($urandom_range(0, 15));
         in_b      = W'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
         clr_stats = ($urandom_range(0, 49) == 0);
         rst       = ($urandom_range(0, 199) == 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0; rst = 1'b0;
      drain("final");
      @(negedge clk);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
